// File: rtl/attn_ctrl_pkg.sv
// Shared state encodings, SFP op codes and instruction field offsets for the attention sequencer.
package attn_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_Q_WRITE    = 4'd1,
    ST_K_WRITE    = 4'd2,
    ST_K_LOAD     = 4'd3,
    ST_EXEC       = 4'd4,
    ST_DRAIN      = 4'd5,
    ST_SFP_ACCUM  = 4'd6,
    ST_SFP_HOLD   = 4'd7,
    ST_SFP_DIV    = 4'd8,
    ST_WRITE_PMEM = 4'd9,
    ST_FINISH     = 4'd10
  } state_t;

  typedef enum logic [1:0] {
    SFP_NONE  = 2'b00,
    SFP_ACCUM = 2'b01,
    SFP_DIV   = 2'b10
  } sfp_op_t;

  localparam int unsigned BIT_PMEM_WR  = 0;
  localparam int unsigned BIT_PMEM_RD  = 1;
  localparam int unsigned BIT_KMEM_WR  = 2;
  localparam int unsigned BIT_KMEM_RD  = 3;
  localparam int unsigned BIT_QMEM_WR  = 4;
  localparam int unsigned BIT_QMEM_RD  = 5;
  localparam int unsigned BIT_LOAD     = 6;
  localparam int unsigned BIT_EXECUTE  = 7;
  localparam int unsigned OFS_PMEM_ADD = 8;

  function automatic int unsigned ofs_qkmem_add(input int unsigned addr_bw);
    return OFS_PMEM_ADD + addr_bw;
  endfunction

  function automatic int unsigned ofs_ofifo_rd(input int unsigned addr_bw);
    return OFS_PMEM_ADD + 2 * addr_bw;
  endfunction

  function automatic int unsigned ofs_sfp(input int unsigned addr_bw);
    return OFS_PMEM_ADD + 2 * addr_bw + 1;
  endfunction

endpackage

// File: rtl/ctrl_step_counter.sv
// Up-counter with synchronous clear that saturates at a terminal value and flags it.
module ctrl_step_counter #(
  parameter int unsigned WIDTH = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] terminal,
  output logic [WIDTH-1:0] count,
  output logic             last
);

  assign last = (count == terminal);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !last) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/attn_seq_ctrl.sv
// Attention-core pass sequencer: Q/K fill, K load, execute, drain, optional SFP, psum write-back.
module attn_seq_ctrl
  import attn_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_BW = 4,
  parameter int unsigned Q_DEPTH = 16,
  parameter int unsigned K_DEPTH = 8,
  parameter int unsigned SFP_EN  = 1,
  parameter int unsigned INST_BW = 2 * ADDR_BW + 11
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               in_valid,
  input  logic               ld_done,
  input  logic               ofifo_full,
  input  logic               ofifo_valid,
  input  logic               sfp_ready,
  output logic [INST_BW-1:0] inst_out,
  output logic               busy,
  output logic               done,
  output logic [3:0]         state_out
);

  localparam int unsigned CW     = ADDR_BW + 1;
  localparam int unsigned QK_OFS = ofs_qkmem_add(ADDR_BW);
  localparam int unsigned OF_OFS = ofs_ofifo_rd(ADDR_BW);
  localparam int unsigned SF_OFS = ofs_sfp(ADDR_BW);

  localparam logic [CW-1:0] Q_LAST = CW'(Q_DEPTH - 1);
  localparam logic [CW-1:0] K_LAST = CW'(K_DEPTH - 1);
  localparam logic [CW-1:0] K_END  = CW'(K_DEPTH);

  state_t             state_q, state_d;
  logic [INST_BW-1:0] inst_d;

  logic          cnt_clr, cnt_en, cnt_last;
  logic [CW-1:0] cnt, cnt_term;
  logic          row_clr, row_en, row_last;
  logic [CW-1:0] row;

  ctrl_step_counter #(.WIDTH(CW)) u_addr_cnt (
    .clk      (clk),
    .reset    (reset),
    .clear    (cnt_clr),
    .enable   (cnt_en),
    .terminal (cnt_term),
    .count    (cnt),
    .last     (cnt_last)
  );

  ctrl_step_counter #(.WIDTH(CW)) u_row_cnt (
    .clk      (clk),
    .reset    (reset),
    .clear    (row_clr),
    .enable   (row_en),
    .terminal (Q_LAST),
    .count    (row),
    .last     (row_last)
  );

  always_comb begin
    state_d  = state_q;
    inst_d   = '0;
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;
    cnt_term = Q_LAST;
    row_clr  = 1'b0;
    row_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_Q_WRITE;
          cnt_clr = 1'b1;
          row_clr = 1'b1;
        end
      end
      ST_Q_WRITE: begin
        cnt_term = Q_LAST;
        if (in_valid) begin
          inst_d[BIT_QMEM_WR]          = 1'b1;
          inst_d[QK_OFS +: ADDR_BW]    = cnt[ADDR_BW-1:0];
          if (cnt_last) begin
            cnt_clr = 1'b1;
            state_d = ST_K_WRITE;
          end else begin
            cnt_en = 1'b1;
          end
        end
      end
      ST_K_WRITE: begin
        cnt_term = K_LAST;
        if (in_valid) begin
          inst_d[BIT_KMEM_WR]          = 1'b1;
          inst_d[QK_OFS +: ADDR_BW]    = cnt[ADDR_BW-1:0];
          if (cnt_last) begin
            cnt_clr = 1'b1;
            state_d = ST_K_LOAD;
          end else begin
            cnt_en = 1'b1;
          end
        end
      end
      ST_K_LOAD: begin
        // Counter runs one past the last K row so the wait phase is distinguishable.
        cnt_term         = K_END;
        inst_d[BIT_LOAD] = 1'b1;
        if (!cnt_last) begin
          inst_d[BIT_KMEM_RD]       = 1'b1;
          inst_d[QK_OFS +: ADDR_BW] = cnt[ADDR_BW-1:0];
          cnt_en                    = 1'b1;
        end else if (ld_done) begin
          cnt_clr = 1'b1;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (!ofifo_full) begin
          inst_d[BIT_EXECUTE]       = 1'b1;
          inst_d[BIT_QMEM_RD]       = 1'b1;
          inst_d[QK_OFS +: ADDR_BW] = row[ADDR_BW-1:0];
          if (row_last) begin
            row_clr = 1'b1;
            state_d = ST_DRAIN;
          end else begin
            row_en = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (ofifo_valid) begin
          inst_d[OF_OFS] = 1'b1;
          state_d        = (SFP_EN != 0) ? ST_SFP_ACCUM : ST_WRITE_PMEM;
        end
      end
      ST_SFP_ACCUM: begin
        inst_d[SF_OFS +: 2] = SFP_ACCUM;
        state_d             = ST_SFP_HOLD;
      end
      ST_SFP_HOLD: begin
        if (sfp_ready) state_d = ST_SFP_DIV;
      end
      ST_SFP_DIV: begin
        inst_d[SF_OFS +: 2] = SFP_DIV;
        state_d             = ST_WRITE_PMEM;
      end
      ST_WRITE_PMEM: begin
        inst_d[BIT_PMEM_WR]             = 1'b1;
        inst_d[OFS_PMEM_ADD +: ADDR_BW] = row[ADDR_BW-1:0];
        if (row_last) begin
          row_clr = 1'b1;
          state_d = ST_FINISH;
        end else begin
          row_en  = 1'b1;
          state_d = ST_DRAIN;
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      inst_out <= '0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      inst_out <= inst_d;
      done     <= (state_q == ST_FINISH);
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign state_out = state_q;

endmodule

// File: tb/tb_attn_seq_ctrl.sv
// Directed bench for attn_seq_ctrl: default SFP configuration and a 4-row no-SFP configuration.
module tb_attn_seq_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b0;

  logic a_start = 0, a_in_valid = 0, a_ld_done = 0, a_ofifo_full = 0, a_ofifo_valid = 0, a_sfp_ready = 0;
  logic [18:0] a_inst;
  logic        a_busy, a_done;
  logic [3:0]  a_state;

  logic b_start = 0, b_in_valid = 0, b_ld_done = 0, b_ofifo_full = 0, b_ofifo_valid = 0, b_sfp_ready = 0;
  logic [18:0] b_inst;
  logic        b_busy, b_done;
  logic [3:0]  b_state;

  int vectors = 0;
  int errors  = 0;

  localparam logic [18:0] W_PWR  = 19'h00001;
  localparam logic [18:0] W_KWR  = 19'h00004;
  localparam logic [18:0] W_KRD  = 19'h00008;
  localparam logic [18:0] W_QWR  = 19'h00010;
  localparam logic [18:0] W_QRD  = 19'h00020;
  localparam logic [18:0] W_LOAD = 19'h00040;
  localparam logic [18:0] W_EXEC = 19'h00080;
  localparam logic [18:0] W_OFRD = 19'h10000;
  localparam logic [18:0] W_ACC  = 19'h20000;
  localparam logic [18:0] W_DIV  = 19'h40000;

  attn_seq_ctrl #(.ADDR_BW(4), .Q_DEPTH(16), .K_DEPTH(8), .SFP_EN(1)) dut_a (
    .clk(clk), .reset(reset), .start(a_start), .in_valid(a_in_valid), .ld_done(a_ld_done),
    .ofifo_full(a_ofifo_full), .ofifo_valid(a_ofifo_valid), .sfp_ready(a_sfp_ready),
    .inst_out(a_inst), .busy(a_busy), .done(a_done), .state_out(a_state)
  );

  attn_seq_ctrl #(.ADDR_BW(4), .Q_DEPTH(4), .K_DEPTH(8), .SFP_EN(0)) dut_b (
    .clk(clk), .reset(reset), .start(b_start), .in_valid(b_in_valid), .ld_done(b_ld_done),
    .ofifo_full(b_ofifo_full), .ofifo_valid(b_ofifo_valid), .sfp_ready(b_sfp_ready),
    .inst_out(b_inst), .busy(b_busy), .done(b_done), .state_out(b_state)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_start_pass();
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    vectors++;
    if (a_state !== 4'd1 || a_inst !== 19'h0) begin
      errors++;
      $display("FAIL start_a state=%0d inst=%h required state=1 inst=00000", a_state, a_inst);
    end
  endtask

  task automatic a_q_fill(input bit toggle);
    logic [18:0] exp;
    int unsigned addr = 0;
    int n = toggle ? 32 : 16;
    for (int k = 0; k < n; k++) begin
      a_in_valid = toggle ? (k % 2 == 0) : 1'b1;
      tick();
      exp = a_in_valid ? (W_QWR | (19'(addr) << 12)) : 19'h0;
      if (a_in_valid) addr++;
      vectors++;
      if (a_inst !== exp) begin
        errors++;
        $display("FAIL q_fill k=%0d inst=%h required=%h", k, a_inst, exp);
      end
    end
    a_in_valid = 1'b0;
    vectors++;
    if (a_state !== 4'd2) begin
      errors++;
      $display("FAIL q_fill_end state=%0d required=2", a_state);
    end
  endtask

  task automatic a_k_fill();
    logic [18:0] exp;
    for (int i = 0; i < 8; i++) begin
      a_in_valid = 1'b1;
      tick();
      exp = W_KWR | (19'(i) << 12);
      vectors++;
      if (a_inst !== exp) begin
        errors++;
        $display("FAIL k_fill i=%0d inst=%h required=%h", i, a_inst, exp);
      end
    end
    a_in_valid = 1'b0;
    vectors++;
    if (a_state !== 4'd3) begin
      errors++;
      $display("FAIL k_fill_end state=%0d required=3", a_state);
    end
  endtask

  task automatic a_k_load();
    logic [18:0] exp;
    for (int i = 0; i < 8; i++) begin
      a_ld_done = (i >= 5);
      tick();
      exp = W_LOAD | W_KRD | (19'(i) << 12);
      vectors++;
      if (a_inst !== exp) begin
        errors++;
        $display("FAIL k_load_rd i=%0d inst=%h required=%h", i, a_inst, exp);
      end
    end
    for (int i = 0; i < 3; i++) begin
      a_ld_done = (i == 2);
      tick();
      vectors++;
      if (a_inst !== W_LOAD) begin
        errors++;
        $display("FAIL k_load_wait i=%0d inst=%h required=%h", i, a_inst, W_LOAD);
      end
    end
    a_ld_done = 1'b0;
    vectors++;
    if (a_state !== 4'd4) begin
      errors++;
      $display("FAIL k_load_end state=%0d required=4", a_state);
    end
  endtask

  task automatic a_exec(input int stall_row, input int stall_n, input int stop_row);
    logic [18:0] exp;
    for (int r = 0; r < stop_row; r++) begin
      if (r == stall_row) begin
        for (int s = 0; s < stall_n; s++) begin
          a_ofifo_full = 1'b1;
          tick();
          vectors++;
          if (a_inst !== 19'h0) begin
            errors++;
            $display("FAIL exec_stall s=%0d inst=%h required=00000", s, a_inst);
          end
        end
        a_ofifo_full = 1'b0;
      end
      tick();
      exp = W_EXEC | W_QRD | (19'(r) << 12);
      vectors++;
      if (a_inst !== exp) begin
        errors++;
        $display("FAIL exec row=%0d inst=%h required=%h", r, a_inst, exp);
      end
    end
    if (stop_row == 16) begin
      vectors++;
      if (a_state !== 4'd5) begin
        errors++;
        $display("FAIL exec_end state=%0d required=5", a_state);
      end
    end
  endtask

  task automatic a_drain_sfp();
    logic [18:0] exp;
    for (int r = 0; r < 16; r++) begin
      if (r == 0) begin
        for (int w = 0; w < 2; w++) begin
          tick();
          vectors++;
          if (a_inst !== 19'h0) begin
            errors++;
            $display("FAIL drain_wait w=%0d inst=%h required=00000", w, a_inst);
          end
        end
      end
      a_ofifo_valid = 1'b1;
      tick();
      a_ofifo_valid = 1'b0;
      vectors++;
      if (a_inst !== W_OFRD) begin
        errors++;
        $display("FAIL ofifo_rd row=%0d inst=%h required=%h", r, a_inst, W_OFRD);
      end
      tick();
      vectors++;
      if (a_inst !== W_ACC) begin
        errors++;
        $display("FAIL sfp_accum row=%0d inst=%h required=%h", r, a_inst, W_ACC);
      end
      for (int h = 0; h < 4; h++) begin
        a_sfp_ready = (h == 3);
        tick();
        vectors++;
        if (a_inst !== 19'h0) begin
          errors++;
          $display("FAIL sfp_hold row=%0d h=%0d inst=%h required=00000", r, h, a_inst);
        end
      end
      a_sfp_ready = 1'b0;
      tick();
      vectors++;
      if (a_inst !== W_DIV) begin
        errors++;
        $display("FAIL sfp_div row=%0d inst=%h required=%h", r, a_inst, W_DIV);
      end
      tick();
      exp = W_PWR | (19'(r) << 8);
      vectors++;
      if (a_inst !== exp) begin
        errors++;
        $display("FAIL pmem_wr row=%0d inst=%h required=%h", r, a_inst, exp);
      end
    end
    vectors++;
    if (a_state !== 4'd10 || a_busy !== 1'b1 || a_done !== 1'b0) begin
      errors++;
      $display("FAIL finish_entry state=%0d busy=%b done=%b required 10/1/0", a_state, a_busy, a_done);
    end
  endtask

  task automatic a_finish(input logic start_in_finish);
    a_start = start_in_finish;
    tick();
    a_start = 1'b0;
    vectors++;
    if (a_inst !== 19'h0 || a_done !== 1'b1 || a_busy !== 1'b0 || a_state !== 4'd0) begin
      errors++;
      $display("FAIL done_pulse inst=%h done=%b busy=%b state=%0d required 00000/1/0/0",
               a_inst, a_done, a_busy, a_state);
    end
    tick();
    vectors++;
    if (a_done !== 1'b0 || a_state !== 4'd0) begin
      errors++;
      $display("FAIL done_clear done=%b state=%0d required 0/0", a_done, a_state);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    tick();
    vectors++;
    if (a_inst !== 19'h0 || a_busy !== 1'b0 || a_done !== 1'b0 || a_state !== 4'd0) begin
      errors++;
      $display("FAIL reset_a inst=%h busy=%b done=%b state=%0d required all 0", a_inst, a_busy, a_done, a_state);
    end
    vectors++;
    if (b_inst !== 19'h0 || b_busy !== 1'b0 || b_done !== 1'b0 || b_state !== 4'd0) begin
      errors++;
      $display("FAIL reset_b inst=%h busy=%b done=%b state=%0d required all 0", b_inst, b_busy, b_done, b_state);
    end
    reset = 1'b1;
    a_start = 1'b0;
    tick();
    vectors++;
    if (a_busy !== 1'b0 || a_inst !== 19'h0) begin
      errors++;
      $display("FAIL idle_hold busy=%b inst=%h required 0/00000", a_busy, a_inst);
    end
  endtask

  task automatic test_fill_load();
    a_start_pass();
    a_q_fill(1'b0);
    a_k_fill();
    a_k_load();
  endtask

  task automatic test_exec_stall();
    a_exec(7, 3, 16);
  endtask

  task automatic test_sfp_drain();
    a_drain_sfp();
    a_finish(1'b1);
  endtask

  task automatic test_in_valid_toggle();
    a_start_pass();
    a_q_fill(1'b1);
    a_k_fill();
    a_k_load();
  endtask

  task automatic test_reset_mid_exec();
    a_exec(99, 0, 5);
    #2;
    reset = 1'b0;
    #1;
    vectors++;
    if (a_inst !== 19'h0 || a_busy !== 1'b0 || a_state !== 4'd0) begin
      errors++;
      $display("FAIL reset_async inst=%h busy=%b state=%0d required 00000/0/0", a_inst, a_busy, a_state);
    end
    tick();
    vectors++;
    if (a_inst !== 19'h0 || a_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_edge inst=%h busy=%b required 00000/0", a_inst, a_busy);
    end
    reset = 1'b1;
    tick();
    a_start_pass();
    a_q_fill(1'b0);
    a_k_fill();
    a_k_load();
    a_exec(99, 0, 16);
    a_drain_sfp();
    a_finish(1'b0);
  endtask

  task automatic test_no_sfp();
    logic [18:0] exp;
    int done_cnt = 0;
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    vectors++;
    if (b_state !== 4'd1 || b_busy !== 1'b1) begin
      errors++;
      $display("FAIL b_start state=%0d busy=%b required 1/1", b_state, b_busy);
    end
    b_in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      exp = W_QWR | (19'(i) << 12);
      vectors++;
      if (b_inst !== exp) begin
        errors++;
        $display("FAIL b_q_fill i=%0d inst=%h required=%h", i, b_inst, exp);
      end
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      exp = W_KWR | (19'(i) << 12);
      vectors++;
      if (b_inst !== exp) begin
        errors++;
        $display("FAIL b_k_fill i=%0d inst=%h required=%h", i, b_inst, exp);
      end
    end
    b_in_valid = 1'b0;
    for (int i = 0; i < 9; i++) begin
      b_ld_done = (i == 8);
      tick();
      exp = (i < 8) ? (W_LOAD | W_KRD | (19'(i) << 12)) : W_LOAD;
      vectors++;
      if (b_inst !== exp) begin
        errors++;
        $display("FAIL b_k_load i=%0d inst=%h required=%h", i, b_inst, exp);
      end
    end
    b_ld_done = 1'b0;
    for (int r = 0; r < 4; r++) begin
      tick();
      exp = W_EXEC | W_QRD | (19'(r) << 12);
      vectors++;
      if (b_inst !== exp) begin
        errors++;
        $display("FAIL b_exec row=%0d inst=%h required=%h", r, b_inst, exp);
      end
    end
    for (int r = 0; r < 4; r++) begin
      b_ofifo_valid = 1'b1;
      tick();
      b_ofifo_valid = 1'b0;
      if (b_done) done_cnt++;
      vectors++;
      if (b_inst !== W_OFRD) begin
        errors++;
        $display("FAIL b_ofifo_rd row=%0d inst=%h required=%h", r, b_inst, W_OFRD);
      end
      tick();
      if (b_done) done_cnt++;
      exp = W_PWR | (19'(r) << 8);
      vectors++;
      if (b_inst !== exp) begin
        errors++;
        $display("FAIL b_pmem_wr row=%0d inst=%h required=%h", r, b_inst, exp);
      end
    end
    tick();
    if (b_done) done_cnt++;
    vectors++;
    if (b_done !== 1'b1 || b_busy !== 1'b0 || b_inst !== 19'h0) begin
      errors++;
      $display("FAIL b_done done=%b busy=%b inst=%h required 1/0/00000", b_done, b_busy, b_inst);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      if (b_done) done_cnt++;
    end
    vectors++;
    if (done_cnt != 1) begin
      errors++;
      $display("FAIL b_done_count count=%0d required=1", done_cnt);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fill_load();
    test_exec_stall();
    test_sfp_drain();
    test_in_valid_toggle();
    test_reset_mid_exec();
    test_no_sfp();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
